// File: rtl/ccr_unit.sv
// Condition-code register stage: masked ALU flag capture, SETC/CLRC, jump resolution with
// tested-flag clear. Optional interrupt shadow copy is enabled by defining CCR_SHADOW_EN.
`ifndef ALU_NOP
`define ALU_NOP 4'd0
`endif
`ifndef ALU_INC
`define ALU_INC 4'd1
`endif
`ifndef ALU_DEC
`define ALU_DEC 4'd2
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd3
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd4
`endif
`ifndef ALU_NOT
`define ALU_NOT 4'd5
`endif
`ifndef ALU_AND
`define ALU_AND 4'd6
`endif
`ifndef ALU_OR
`define ALU_OR 4'd7
`endif
`ifndef ALU_SHL
`define ALU_SHL 4'd8
`endif
`ifndef ALU_SHR
`define ALU_SHR 4'd9
`endif
`ifndef ALU_MOV
`define ALU_MOV 4'd10
`endif

module ccr_unit (
  input  logic       clk,
  input  logic       rstN,
  input  logic       stall,
  input  logic [3:0] aluSignals,
  input  logic       zeroIn,
  input  logic       carryIn,
  input  logic       overFlowIn,
  input  logic       negativeIn,
  input  logic       flagWriteEn,
  input  logic       setCarry,
  input  logic       clrCarry,
  input  logic       jumpValid,
  input  logic [1:0] jumpType,
  input  logic       intSave,
  input  logic       rtiRestore,
  output logic [3:0] ccr,
  output logic       jumpTaken,
  output logic       shadowValid
);

  localparam int unsigned BitZ = 0;
  localparam int unsigned BitN = 1;
  localparam int unsigned BitC = 2;
  localparam int unsigned BitV = 3;

  logic [3:0] ccr_q, ccr_d;
  logic [3:0] ccr_upd;
  logic       upd_all, upd_zn;
  logic       sel_flag;

  always_comb begin
    upd_all = 1'b0;
    upd_zn  = 1'b0;
    case (aluSignals)
      `ALU_INC, `ALU_DEC, `ALU_ADD, `ALU_SUB:           upd_all = 1'b1;
      `ALU_NOT, `ALU_AND, `ALU_OR, `ALU_SHL, `ALU_SHR: upd_zn  = 1'b1;
      default: ;
    endcase
  end

  // JZ/JN/JC test bits 0/1/2, which line up with the jump type encoding
  always_comb begin
    sel_flag  = (jumpType == 2'd3) ? 1'b1 : ccr_q[jumpType];
    jumpTaken = jumpValid & sel_flag;
  end

  always_comb begin
    ccr_upd = ccr_q;
    if (jumpTaken && (jumpType != 2'd3)) begin
      ccr_upd[jumpType] = 1'b0;
    end
    if (flagWriteEn && (upd_all || upd_zn)) begin
      ccr_upd[BitZ] = zeroIn;
      ccr_upd[BitN] = negativeIn;
    end
    if (flagWriteEn && upd_all) begin
      ccr_upd[BitC] = carryIn;
      ccr_upd[BitV] = overFlowIn;
    end
    if (clrCarry) begin
      ccr_upd[BitC] = 1'b0;
    end else if (setCarry) begin
      ccr_upd[BitC] = 1'b1;
    end
  end

`ifdef CCR_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;
  logic       shadow_valid_q, shadow_valid_d;

  always_comb begin
    ccr_d          = ccr_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (!stall) begin
      if (rtiRestore) begin
        ccr_d          = shadow_q;
        shadow_valid_d = 1'b0;
      end else begin
        ccr_d = ccr_upd;
        // The shadow captures the value committed on this same edge
        if (intSave) begin
          shadow_d       = ccr_upd;
          shadow_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shadow_q       <= 4'b0000;
      shadow_valid_q <= 1'b0;
    end else begin
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign shadowValid = shadow_valid_q;
`else
  logic unused_shadow_inputs;
  assign unused_shadow_inputs = intSave ^ rtiRestore;

  always_comb begin
    ccr_d = ccr_q;
    if (!stall) begin
      ccr_d = ccr_upd;
    end
  end

  assign shadowValid = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ccr_q <= 4'b0000;
    end else begin
      ccr_q <= ccr_d;
    end
  end

  assign ccr = ccr_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: directed scenarios plus randomized traffic against a
// flag-level reference model. Expectations follow CCR_SHADOW_EN when it is defined.
module tb_ccr_unit;

  localparam logic [3:0] OpNop = 4'd0, OpInc = 4'd1, OpDec = 4'd2, OpAdd = 4'd3, OpSub = 4'd4;
  localparam logic [3:0] OpNot = 4'd5, OpAnd = 4'd6, OpOr = 4'd7, OpShl = 4'd8, OpShr = 4'd9;
  localparam logic [3:0] OpMov = 4'd10;
`ifdef CCR_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flag_we, set_c, clr_c, jump_valid, int_save, rti;
  logic [3:0] alu_op;
  logic       z_in, c_in, v_in, n_in;
  logic [1:0] jump_type;
  logic [3:0] ccr;
  logic       jump_taken, shadow_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state, named by flag
  bit m_z, m_n, m_c, m_v;
  bit [3:0] m_shadow;
  bit m_sv;

  ccr_unit dut (
    .clk        (clk),
    .rstN       (rst_n),
    .stall      (stall),
    .aluSignals (alu_op),
    .zeroIn     (z_in),
    .carryIn    (c_in),
    .overFlowIn (v_in),
    .negativeIn (n_in),
    .flagWriteEn(flag_we),
    .setCarry   (set_c),
    .clrCarry   (clr_c),
    .jumpValid  (jump_valid),
    .jumpType   (jump_type),
    .intSave    (int_save),
    .rtiRestore (rti),
    .ccr        (ccr),
    .jumpTaken  (jump_taken),
    .shadowValid(shadow_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_ccr();
    return {m_v, m_c, m_n, m_z};
  endfunction

  function automatic bit m_jump();
    bit flag;
    case (jump_type)
      2'd0: flag = m_z;
      2'd1: flag = m_n;
      2'd2: flag = m_c;
      default: flag = 1'b1;
    endcase
    return jump_valid && flag;
  endfunction

  task automatic m_reset();
    {m_v, m_c, m_n, m_z} = 4'b0000;
    m_shadow = 4'b0000;
    m_sv = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently driven
  task automatic m_edge();
    bit z, n, c, v;
    if (stall) return;
    if (ShadowEn && rti) begin
      {m_v, m_c, m_n, m_z} = m_shadow;
      m_sv = 1'b0;
      return;
    end
    z = m_z; n = m_n; c = m_c; v = m_v;
    if (m_jump()) begin
      if (jump_type == 2'd0) z = 1'b0;
      if (jump_type == 2'd1) n = 1'b0;
      if (jump_type == 2'd2) c = 1'b0;
    end
    if (flag_we && (alu_op inside {OpInc, OpDec, OpAdd, OpSub})) begin
      z = z_in; n = n_in; c = c_in; v = v_in;
    end else if (flag_we && (alu_op inside {OpNot, OpAnd, OpOr, OpShl, OpShr})) begin
      z = z_in; n = n_in;
    end
    if (clr_c) c = 1'b0;
    else if (set_c) c = 1'b1;
    m_z = z; m_n = n; m_c = c; m_v = v;
    if (ShadowEn && int_save) begin
      m_shadow = {v, c, n, z};
      m_sv = 1'b1;
    end
  endtask

  task automatic set_idle();
    stall = 0; flag_we = 0; set_c = 0; clr_c = 0; jump_valid = 0; int_save = 0; rti = 0;
    alu_op = OpNop; jump_type = 2'd0; {v_in, c_in, n_in, z_in} = 4'b0000;
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [3:0] f);
    alu_op = op; flag_we = 1'b1;
    {v_in, c_in, n_in, z_in} = f;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 0; flag_we = 1; set_c = 1; clr_c = 0; jump_valid = 1; int_save = 1; rti = 1;
    alu_op = OpAdd; jump_type = 2'd3; {v_in, c_in, n_in, z_in} = 4'b1111;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL reset_ccr: got %b want 0000", ccr);
    end
    checks++;
    if (shadow_valid !== 1'b0) begin
      errors++; $display("FAIL reset_sv: got %b want 0", shadow_valid);
    end
    checks++;
    if (jump_taken !== 1'b1) begin
      errors++; $display("FAIL reset_jmp: got %b want 1", jump_taken);
    end
    set_idle();
    #1 rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL reset_idle: got %b want 0000", ccr);
    end
  endtask

  task automatic test_masks();
    set_alu(OpAdd, 4'b1110);
    tick();
    checks++;
    if (ccr !== 4'b1110) begin
      errors++; $display("FAIL mask_add: got %b want 1110", ccr);
    end
    set_alu(OpAnd, 4'b0001);
    tick();
    checks++;
    if (ccr !== 4'b1101) begin
      errors++; $display("FAIL mask_and: got %b want 1101", ccr);
    end
    set_alu(OpMov, 4'b0000);
    tick();
    checks++;
    if (ccr !== 4'b1101) begin
      errors++; $display("FAIL mask_mov: got %b want 1101", ccr);
    end
    set_alu(4'd14, 4'b0010);
    tick();
    checks++;
    if (ccr !== 4'b1101) begin
      errors++; $display("FAIL mask_undef: got %b want 1101", ccr);
    end
    set_idle();
  endtask

  task automatic test_jump();
    set_alu(OpAdd, 4'b0001);
    tick();
    set_idle();
    jump_valid = 1; jump_type = 2'd0;
    #1;
    checks++;
    if (jump_taken !== 1'b1) begin
      errors++; $display("FAIL jz_taken: got %b want 1", jump_taken);
    end
    tick();
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL jz_clear: got %b want 0000", ccr);
    end
    set_alu(OpSub, 4'b1011);
    tick();
    set_idle();
    jump_valid = 1; jump_type = 2'd2;
    #1;
    checks++;
    if (jump_taken !== 1'b0) begin
      errors++; $display("FAIL jc_not_taken: got %b want 0", jump_taken);
    end
    tick();
    checks++;
    if (ccr !== 4'b1011) begin
      errors++; $display("FAIL jc_hold: got %b want 1011", ccr);
    end
    jump_type = 2'd3;
    #1;
    checks++;
    if (jump_taken !== 1'b1) begin
      errors++; $display("FAIL jmp_taken: got %b want 1", jump_taken);
    end
    tick();
    checks++;
    if (ccr !== 4'b1011) begin
      errors++; $display("FAIL jmp_hold: got %b want 1011", ccr);
    end
    set_idle();
  endtask

  task automatic test_conflicts();
    set_alu(OpAdd, 4'b0100);
    tick();
    jump_valid = 1; jump_type = 2'd2;
    #1;
    checks++;
    if (jump_taken !== 1'b1) begin
      errors++; $display("FAIL jc_alu_taken: got %b want 1", jump_taken);
    end
    tick();
    checks++;
    if (ccr !== 4'b0100) begin
      errors++; $display("FAIL jc_alu_override: got %b want 0100", ccr);
    end
    set_idle();
    set_c = 1; clr_c = 1;
    tick();
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL setc_clrc: got %b want 0000", ccr);
    end
    set_idle();
    stall = 1; set_alu(OpAdd, 4'b1111);
    tick();
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL stall_hold: got %b want 0000", ccr);
    end
    set_idle();
  endtask

  task automatic test_shadow();
    logic [3:0] want_rti;
    want_rti = ShadowEn ? 4'b1010 : 4'b0001;
    set_alu(OpAdd, 4'b1010); int_save = 1;
    tick();
    checks++;
    if (ccr !== 4'b1010 || shadow_valid !== ShadowEn) begin
      errors++; $display("FAIL shadow_save: got %b/%b want 1010/%b", ccr, shadow_valid, ShadowEn);
    end
    set_idle(); clr_c = 1;
    tick();
    checks++;
    if (ccr !== 4'b1010) begin
      errors++; $display("FAIL shadow_clrc: got %b want 1010", ccr);
    end
    set_idle(); set_alu(OpSub, 4'b0001);
    tick();
    checks++;
    if (ccr !== 4'b0001) begin
      errors++; $display("FAIL shadow_sub: got %b want 0001", ccr);
    end
    set_idle(); rti = 1;
    tick();
    checks++;
    if (ccr !== want_rti || shadow_valid !== 1'b0) begin
      errors++; $display("FAIL shadow_rti: got %b/%b want %b/0", ccr, shadow_valid, want_rti);
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    set_alu(OpInc, 4'b1111); int_save = 1;
    tick();
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (ccr !== 4'b0000 || shadow_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got %b/%b want 0000/0", ccr, shadow_valid);
    end
    set_idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_idle(); rti = 1;
    tick();
    checks++;
    if (ccr !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_rti: got %b want 0000", ccr);
    end
    set_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(7) == 0);
      flag_we    = ($urandom_range(3) != 0);
      alu_op     = 4'($urandom_range(15));
      {v_in, c_in, n_in, z_in} = 4'($urandom);
      set_c      = ($urandom_range(5) == 0);
      clr_c      = ($urandom_range(5) == 0);
      jump_valid = ($urandom_range(1) == 0);
      jump_type  = 2'($urandom_range(3));
      int_save   = ($urandom_range(5) == 0);
      rti        = ($urandom_range(7) == 0);
      #1;
      checks++;
      if (jump_taken !== m_jump()) begin
        errors++; $display("FAIL rand_jump[%0d]: got %b want %b", i, jump_taken, m_jump());
      end
      tick();
      checks++;
      if (ccr !== m_ccr() || shadow_valid !== m_sv) begin
        errors++;
        $display("FAIL rand_state[%0d]: got %b/%b want %b/%b", i, ccr, shadow_valid, m_ccr(),
                 m_sv);
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_masks();
    test_jump();
    test_conflicts();
    test_shadow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
